enc8b10b_tx_framer: RTL



---
 rtl/enc8b10b_tx_framer.sv | 91 +++++++++
 1 files changed

// File: rtl/enc8b10b_tx_framer.sv
// Symbol scheduler for the 8b10b encoder input: K28.5 idle commas, and SOF/data/EOF
// framing around byte-stream packets. Running disparity is left to the encoder.
module enc8b10b_tx_framer #(
  parameter int MIN_IDLE = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic             enc_ein,
  output logic             enc_kin,
  output logic [7:0]       enc_dat,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] undr_cnt
);
  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam logic [7:0] K_SOF   = 8'hFB;
  localparam logic [7:0] K_EOF   = 8'hFD;
  localparam logic [7:0] K_FILL  = 8'hF7;
  localparam logic [7:0] GAP     = MIN_IDLE[7:0];

  typedef enum logic [2:0] {S_OFF, S_IDLE, S_SOF, S_DATA, S_EOF} state_t;

  state_t     state;
  logic [7:0] idle_cnt;

  assign s_ready = (state == S_DATA);
  assign busy    = (state == S_SOF) || (state == S_DATA) || (state == S_EOF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_OFF;
      idle_cnt <= 8'h00;
      enc_ein  <= 1'b0;
      enc_kin  <= 1'b0;
      enc_dat  <= 8'h00;
      pkt_cnt  <= '0;
      undr_cnt <= '0;
    end else begin
      enc_ein <= 1'b0;
      enc_kin <= 1'b0;
      enc_dat <= 8'h00;
      case (state)
        S_OFF: begin
          if (tx_en) begin
            state    <= S_IDLE;
            idle_cnt <= 8'h00;
          end
        end
        S_IDLE: begin
          enc_kin <= 1'b1;
          enc_dat <= K_COMMA;
          if (idle_cnt != 8'hFF) idle_cnt <= idle_cnt + 8'(1);
          // idle_cnt here is the number of commas already on the wire
          if (!tx_en)                             state <= S_OFF;
          else if (s_valid && (idle_cnt >= GAP))  state <= S_SOF;
        end
        S_SOF: begin
          enc_kin <= 1'b1;
          enc_dat <= K_SOF;
          state   <= S_DATA;
        end
        S_DATA: begin
          if (s_valid) begin
            enc_ein <= 1'b1;
            enc_dat <= s_data;
            if (s_last) state <= S_EOF;
          end else begin
            // underrun: keep the symbol stream continuous with a filler K-code
            enc_kin <= 1'b1;
            enc_dat <= K_FILL;
            if (undr_cnt != '1) undr_cnt <= undr_cnt + CNT_W'(1);
          end
        end
        S_EOF: begin
          enc_kin  <= 1'b1;
          enc_dat  <= K_EOF;
          idle_cnt <= 8'h00;
          if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + CNT_W'(1);
          state    <= tx_en ? S_IDLE : S_OFF;
        end
        default: state <= S_OFF;
      endcase
    end
  end
endmodule
